// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// ALU op codes, muldiv class encodings, FSM state enum, iteration count
// and small op-decode helpers.
package muldiv_seq_pkg;

  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 4'd7;

  localparam logic [1:0] MD_CLASS_MUL = 2'b01;
  localparam logic [1:0] MD_CLASS_DIV = 2'b10;

  localparam int ITER_COUNT = 32;
  localparam int ITER_CNT_W = 6;
  localparam logic [ITER_CNT_W-1:0] ITER_LAST = ITER_CNT_W'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // rs1 is treated as signed by MUL, MULH and MULHSU
  function automatic logic mul_a_signed(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU);
  endfunction

  // rs2 is treated as signed by MUL and MULH only
  function automatic logic mul_b_signed(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH);
  endfunction

  function automatic logic div_signed(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider core: one quotient bit per cycle on operand magnitudes,
// sign-corrected results presented combinationally during the final
// iteration cycle (done_o) so the caller can capture them on that edge.
// Zero divisor and signed overflow are handled by the caller, not here.
module muldiv_div_core
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  logic                  busy_q, busy_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]       rem_q, rem_d;
  logic [XLEN-1:0]       quo_q, quo_d;
  logic [XLEN-1:0]       dvs_q, dvs_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;

  logic            dividend_neg;
  logic            divisor_neg;
  logic [XLEN-1:0] dividend_mag;
  logic [XLEN-1:0] divisor_mag;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic            last_iter;

  // Operand magnitudes and one restoring step (shift in next dividend bit, trial subtract)
  always_comb begin
    dividend_neg = signed_i & dividend_i[XLEN-1];
    divisor_neg  = signed_i & divisor_i[XLEN-1];
    dividend_mag = dividend_neg ? -dividend_i : dividend_i;
    divisor_mag  = divisor_neg ? -divisor_i : divisor_i;
    rem_shift    = {rem_q, quo_q[XLEN-1]};
    trial        = rem_shift - {1'b0, dvs_q};
    rem_next     = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
    quo_next     = {quo_q[XLEN-2:0], ~trial[XLEN]};
    last_iter    = busy_q && (cnt_q == ITER_LAST);
    done_o       = last_iter;
    quotient_o   = q_neg_q ? -quo_next : quo_next;
    remainder_o  = r_neg_q ? -rem_next : rem_next;
  end

  // Next-state for the iteration registers: abort wins, then start, then iterate
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = dividend_mag;
      dvs_d   = divisor_mag;
      q_neg_d = dividend_neg ^ divisor_neg;
      r_neg_d = dividend_neg;
    end else if (busy_q) begin
      rem_d = rem_next;
      quo_d = quo_next;
      cnt_d = cnt_q + ITER_CNT_W'(1);
      if (last_iter) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // Divider state registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit with IDLE/MUL/DIV/DONE FSM.
// Multiply: 32-step shift-add on magnitudes; divide: restoring core
// (muldiv_div_core). Zero divisor and signed overflow finish immediately.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle 64-bit
// multiply (IDLE->DONE); divide timing is the same in both builds.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [1:0]              is_muldiv_i,
  input  logic [ALU_OP_WIDTH-1:0] op_i,
  input  logic [XLEN-1:0]         operand_a_i,
  input  logic [XLEN-1:0]         operand_b_i,
  input  logic                    kill_i,
  output logic                    stall_o,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic [XLEN-1:0]         result_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e             state_q, state_d;
  logic [ALU_OP_WIDTH-1:0] op_q, op_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]       cand_q, cand_d;
  logic                  mul_neg_q, mul_neg_d;
  logic [XLEN-1:0]       result_q, result_d;

  logic              is_mul_class;
  logic              is_div_class;
  logic              accept;
  logic              mul_a_neg;
  logic              mul_b_neg;
  logic [XLEN-1:0]   mul_a_mag;
  logic [XLEN-1:0]   mul_b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod_next;
  logic [2*XLEN-1:0] mul_prod_signed;
  logic              div_zero;
  logic              div_ovf;
  logic              div_start;
  logic [XLEN-1:0]   div_quotient;
  logic [XLEN-1:0]   div_remainder;
  logic              div_done;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a_ext;
  logic [2*XLEN-1:0] fast_b_ext;
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Issue decode, multiply magnitudes and one shift-add step
  always_comb begin
    is_mul_class    = (is_muldiv_i == MD_CLASS_MUL);
    is_div_class    = (is_muldiv_i == MD_CLASS_DIV);
    accept          = (state_q == IDLE) && start_i && (is_mul_class || is_div_class) && !kill_i;
    mul_a_neg       = mul_a_signed(op_i) & operand_a_i[XLEN-1];
    mul_b_neg       = mul_b_signed(op_i) & operand_b_i[XLEN-1];
    mul_a_mag       = mul_a_neg ? -operand_a_i : operand_a_i;
    mul_b_mag       = mul_b_neg ? -operand_b_i : operand_b_i;
    mul_sum         = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, cand_q} : '0);
    mul_prod_next   = {mul_sum, prod_q[XLEN-1:1]};
    mul_prod_signed = mul_neg_q ? -mul_prod_next : mul_prod_next;
    div_zero        = (operand_b_i == '0);
    div_ovf         = div_signed(op_i) && (operand_a_i == INT_MIN) && (operand_b_i == '1);
    div_start       = accept && is_div_class && !div_zero && !div_ovf;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Full-width product of sign/zero-extended operands; low 2*XLEN bits are exact
  always_comb begin
    fast_a_ext = {{XLEN{mul_a_signed(op_i) & operand_a_i[XLEN-1]}}, operand_a_i};
    fast_b_ext = {{XLEN{mul_b_signed(op_i) & operand_b_i[XLEN-1]}}, operand_b_i};
    fast_prod  = fast_a_ext * fast_b_ext;
  end
`endif

  muldiv_div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (div_start),
    .abort_i    (kill_i),
    .signed_i   (div_signed(op_i)),
    .dividend_i (operand_a_i),
    .divisor_i  (operand_b_i),
    .quotient_o (div_quotient),
    .remainder_o(div_remainder),
    .done_o     (div_done)
  );

  // FSM next state and datapath updates; kill overrides everything at the end
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    cand_d    = cand_q;
    mul_neg_d = mul_neg_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = op_i;
          if (is_mul_class) begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = (op_i == ALU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            state_d  = DONE;
`else
            prod_d    = {{XLEN{1'b0}}, mul_b_mag};
            cand_d    = mul_a_mag;
            mul_neg_d = mul_a_neg ^ mul_b_neg;
            cnt_d     = '0;
            state_d   = MUL;
`endif
          end else if (div_zero) begin
            result_d = is_rem_op(op_i) ? operand_a_i : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = is_rem_op(op_i) ? '0 : INT_MIN;
            state_d  = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      MUL: begin
        prod_d = mul_prod_next;
        cnt_d  = cnt_q + ITER_CNT_W'(1);
        if (cnt_q == ITER_LAST) begin
          result_d = (op_q == ALU_MUL) ? mul_prod_signed[XLEN-1:0]
                                       : mul_prod_signed[2*XLEN-1:XLEN];
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DIV: begin
        if (div_done) begin
          result_d = is_rem_op(op_q) ? div_remainder : div_quotient;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (kill_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      prod_q    <= '0;
      cand_q    <= '0;
      mul_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      cand_q    <= cand_d;
      mul_neg_q <= mul_neg_d;
      result_q  <= result_d;
    end
  end

  // Output decode; stall is forced low while reset is held
  always_comb begin
    busy_o   = (state_q != IDLE);
    valid_o  = (state_q == DONE) && !kill_i;
    stall_o  = rst_ni && (accept || (state_q == MUL) || (state_q == DIV));
    result_o = result_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: table of directed ops with
// hand-computed results and latencies, plus kill, reset, ignore and
// back-to-back sequences. Honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int MAX_WAIT = 40;
  localparam int NVEC     = 16;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    start_i = 1'b0;
  logic [1:0]              is_muldiv_i = 2'b00;
  logic [ALU_OP_WIDTH-1:0] op_i = '0;
  logic [XLEN-1:0]         operand_a_i = '0;
  logic [XLEN-1:0]         operand_b_i = '0;
  logic                    kill_i = 1'b0;
  logic                    stall_o;
  logic                    busy_o;
  logic                    valid_o;
  logic [XLEN-1:0]         result_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string                   name;
    logic [1:0]              md;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [XLEN-1:0]         a;
    logic [XLEN-1:0]         b;
    logic [XLEN-1:0]         exp;
    int                      lat;
  } vec_t;

  vec_t vecs[NVEC];

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .is_muldiv_i(is_muldiv_i),
    .op_i       (op_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .kill_i     (kill_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op; latency counted in cycles after the acceptance edge (-1 if never valid)
  task automatic applyStimulus(input logic [1:0] md, input logic [ALU_OP_WIDTH-1:0] op,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               output int lat, output logic [XLEN-1:0] res,
                               output int stall_bad, output logic valid_after,
                               output logic busy_after);
    @(negedge clk_i);
    start_i = 1'b1; is_muldiv_i = md; op_i = op; operand_a_i = a; operand_b_i = b;
    #1;
    stall_bad = stall_o ? 0 : 1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; is_muldiv_i = 2'b00;
    lat = -1; res = '0; valid_after = 1'b0; busy_after = 1'b0;
    for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
      @(negedge clk_i);
      if (valid_o) begin
        lat = cyc;
        res = result_o;
        if (stall_o) stall_bad++;
        break;
      end
      if (!stall_o) stall_bad++;
    end
    if (lat > 0) begin
      @(negedge clk_i);
      valid_after = valid_o;
      busy_after  = busy_o;
    end
  endtask

  initial begin
    int lat;
    int stall_bad;
    int vcount;
    logic [XLEN-1:0] res;
    logic valid_after;
    logic busy_after;
    logic [XLEN-1:0] prev;

    vecs[0]  = '{"MUL 7x-3",        MD_CLASS_MUL, ALU_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
    vecs[1]  = '{"MULHU max x max", MD_CLASS_MUL, ALU_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
    vecs[2]  = '{"MULH min x min",  MD_CLASS_MUL, ALU_MULH,   32'h80000000,  32'h80000000, 32'h40000000, MUL_LAT};
    vecs[3]  = '{"MULHSU -1 x 2",   MD_CLASS_MUL, ALU_MULHSU, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, MUL_LAT};
    vecs[4]  = '{"MULH -1 x -1",    MD_CLASS_MUL, ALU_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, MUL_LAT};
    vecs[5]  = '{"MUL wrap",        MD_CLASS_MUL, ALU_MUL,    32'h12345678,  32'h10,       32'h23456780, MUL_LAT};
    vecs[6]  = '{"DIV -20/3",       MD_CLASS_DIV, ALU_DIV,    32'hFFFFFFEC,  32'd3,        32'hFFFFFFFA, DIV_LAT};
    vecs[7]  = '{"REM -20/3",       MD_CLASS_DIV, ALU_REM,    32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, DIV_LAT};
    vecs[8]  = '{"DIVU 100/7",      MD_CLASS_DIV, ALU_DIVU,   32'd100,       32'd7,        32'd14,       DIV_LAT};
    vecs[9]  = '{"REMU 100/7",      MD_CLASS_DIV, ALU_REMU,   32'd100,       32'd7,        32'd2,        DIV_LAT};
    vecs[10] = '{"DIVU 5/0",        MD_CLASS_DIV, ALU_DIVU,   32'd5,         32'd0,        32'hFFFFFFFF, 1};
    vecs[11] = '{"REM 5/0",         MD_CLASS_DIV, ALU_REM,    32'd5,         32'd0,        32'd5,        1};
    vecs[12] = '{"DIV ovf",         MD_CLASS_DIV, ALU_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
    vecs[13] = '{"REM ovf",         MD_CLASS_DIV, ALU_REM,    32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1};
    vecs[14] = '{"DIVU min/max",    MD_CLASS_DIV, ALU_DIVU,   32'h80000000,  32'hFFFFFFFF, 32'h00000000, DIV_LAT};
    vecs[15] = '{"REM 20/-3",       MD_CLASS_DIV, ALU_REM,    32'd20,        32'hFFFFFFFD, 32'd2,        DIV_LAT};

    // Reset state
    #12;
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    checkOutput("reset stall_o", 32'(stall_o), 32'd0);
    checkOutput("reset result_o", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].md, vecs[i].op, vecs[i].a, vecs[i].b, lat, res, stall_bad, valid_after, busy_after);
      checkOutput({vecs[i].name, " result"}, res, vecs[i].exp);
      checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      checkOutput({vecs[i].name, " stall window"}, 32'(stall_bad), 32'd0);
      checkOutput({vecs[i].name, " single valid"}, 32'(valid_after), 32'd0);
      checkOutput({vecs[i].name, " busy after"}, 32'(busy_after), 32'd0);
    end
    prev = vecs[NVEC-1].exp;

    // Kill at cycle 10 of a DIV
    @(negedge clk_i);
    start_i = 1'b1; is_muldiv_i = MD_CLASS_DIV; op_i = ALU_DIV; operand_a_i = 32'd1000; operand_b_i = 32'd7;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; is_muldiv_i = 2'b00;
    repeat (10) @(negedge clk_i);
    checkOutput("kill c10 busy", 32'(busy_o), 32'd1);
    kill_i = 1'b1;
    #1;
    checkOutput("kill c10 valid", 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    @(negedge clk_i);
    checkOutput("kill c11 busy", 32'(busy_o), 32'd0);
    checkOutput("kill c11 stall", 32'(stall_o), 32'd0);
    checkOutput("kill c11 result", result_o, prev);
    vcount = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    checkOutput("kill no valid", 32'(vcount), 32'd0);
    checkOutput("kill result kept", result_o, prev);

    // start_i together with kill_i is not accepted
    @(negedge clk_i);
    start_i = 1'b1; is_muldiv_i = MD_CLASS_DIV; op_i = ALU_DIVU; operand_a_i = 32'd100; operand_b_i = 32'd7;
    kill_i = 1'b1;
    #1;
    checkOutput("start+kill stall", 32'(stall_o), 32'd0);
    @(posedge clk_i);
    #1;
    start_i = 1'b0; is_muldiv_i = 2'b00; kill_i = 1'b0;
    @(negedge clk_i);
    checkOutput("start+kill busy", 32'(busy_o), 32'd0);
    vcount = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    checkOutput("start+kill no valid", 32'(vcount), 32'd0);

    // is_muldiv_i of 00 and 11 is ignored
    @(negedge clk_i);
    start_i = 1'b1; is_muldiv_i = 2'b00; op_i = ALU_DIVU; operand_a_i = 32'd9; operand_b_i = 32'd0;
    #1;
    checkOutput("md00 stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    checkOutput("md00 busy", 32'(busy_o), 32'd0);
    is_muldiv_i = 2'b11;
    #1;
    checkOutput("md11 stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    checkOutput("md11 busy", 32'(busy_o), 32'd0);
    checkOutput("md11 valid", 32'(valid_o), 32'd0);
    start_i = 1'b0; is_muldiv_i = 2'b00;

    // start_i while busy is ignored
    @(negedge clk_i);
    start_i = 1'b1; is_muldiv_i = MD_CLASS_DIV; op_i = ALU_DIVU; operand_a_i = 32'd100; operand_b_i = 32'd7;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; is_muldiv_i = 2'b00;
    lat = -1; res = '0;
    for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
      @(negedge clk_i);
      if (valid_o) begin
        lat = cyc;
        res = result_o;
        break;
      end
      if (cyc == 5) begin
        start_i = 1'b1; is_muldiv_i = MD_CLASS_MUL; op_i = ALU_MUL; operand_a_i = 32'd3; operand_b_i = 32'd3;
      end else begin
        start_i = 1'b0; is_muldiv_i = 2'b00;
      end
    end
    start_i = 1'b0; is_muldiv_i = 2'b00;
    checkOutput("busy ignore latency", 32'(lat), 32'd33);
    checkOutput("busy ignore result", res, 32'd14);

    // Back-to-back: new op accepted in the IDLE cycle right after DONE
    @(negedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1; is_muldiv_i = MD_CLASS_DIV; op_i = ALU_DIVU; operand_a_i = 32'd5; operand_b_i = 32'd0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; is_muldiv_i = 2'b00;
    @(negedge clk_i);
    checkOutput("b2b first valid", 32'(valid_o), 32'd1);
    checkOutput("b2b first result", result_o, 32'hFFFFFFFF);
    @(negedge clk_i);
    start_i = 1'b1; is_muldiv_i = MD_CLASS_DIV; op_i = ALU_REMU; operand_a_i = 32'd9; operand_b_i = 32'd0;
    #1;
    checkOutput("b2b second accept", 32'(stall_o), 32'd1);
    @(posedge clk_i);
    #1;
    start_i = 1'b0; is_muldiv_i = 2'b00;
    @(negedge clk_i);
    checkOutput("b2b second valid", 32'(valid_o), 32'd1);
    checkOutput("b2b second result", result_o, 32'd9);

    // Reset at cycle 5 of a MUL, then a fresh op
    @(negedge clk_i);
    start_i = 1'b1; is_muldiv_i = MD_CLASS_MUL; op_i = ALU_MUL; operand_a_i = 32'd11; operand_b_i = 32'd13;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; is_muldiv_i = 2'b00;
    repeat (5) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid reset valid", 32'(valid_o), 32'd0);
    checkOutput("mid reset busy", 32'(busy_o), 32'd0);
    checkOutput("mid reset stall", 32'(stall_o), 32'd0);
    checkOutput("mid reset result", result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    vcount = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    checkOutput("mid reset no valid", 32'(vcount), 32'd0);
    applyStimulus(MD_CLASS_MUL, ALU_MUL, 32'd7, 32'hFFFFFFFD, lat, res, stall_bad, valid_after, busy_after);
    checkOutput("post reset result", res, 32'hFFFFFFEB);
    checkOutput("post reset latency", 32'(lat), 32'(MUL_LAT));
    checkOutput("post reset stall window", 32'(stall_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
